chiplet_link_if: RTL and testbench

Link-side adapter between the CPU/chiplet interconnect and the NMCU instruction/response ports. It assembles inbound flit packets into instruction words, buffers them in a small first-word-fall-through FIFO, and presents them on a valid/ready port that drives the NMCU instruction input. It also serializes NMCU response words into outbound flit packets. It sits directly upstream of the NMCU control path.

---
 rtl/chiplet_link_if.sv | 231 +++++++++++++++++++++++
 tb/tb_chiplet_link_if.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chiplet_link_if.sv
// chiplet_link_if: link-side adapter for the NMCU.
// Inbound flits are assembled into instruction words and queued in a
// first-word-fall-through FIFO. Outbound, response words are split into flits.
// The RX and TX paths share only clock and reset.
module chiplet_link_if #(
  parameter int FLIT_WIDTH    = 32,
  parameter int INSTR_WIDTH   = 128,
  parameter int RESP_WIDTH    = 64,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   rx_flit_valid_i,
  input  logic [FLIT_WIDTH-1:0]                  rx_flit_i,
  input  logic                                   rx_flit_last_i,
  output logic                                   rx_flit_ready_o,
  output logic                                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0]                 instr_o,
  input  logic                                   instr_ready_i,
  input  logic                                   resp_valid_i,
  input  logic [RESP_WIDTH-1:0]                  resp_i,
  output logic                                   resp_ready_o,
  output logic                                   tx_flit_valid_o,
  output logic [FLIT_WIDTH-1:0]                  tx_flit_o,
  output logic                                   tx_flit_last_o,
  input  logic                                   tx_flit_ready_i,
  output logic                                   framing_err_o,
  output logic [7:0]                             err_count_o,
  output logic [$clog2(RX_FIFO_DEPTH+1)-1:0]     rx_fifo_count_o
);

  localparam int INSTR_FLITS = INSTR_WIDTH / FLIT_WIDTH;
  localparam int RESP_FLITS  = RESP_WIDTH / FLIT_WIDTH;
  localparam int CNT_W       = (INSTR_FLITS > 1) ? $clog2(INSTR_FLITS) : 1;
  localparam int IDX_W       = (RESP_FLITS > 1) ? $clog2(RESP_FLITS) : 1;
  localparam int PTR_W       = $clog2(RX_FIFO_DEPTH);
  localparam int FCNT_W      = $clog2(RX_FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INSTR_FLITS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RESP_FLITS - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RX_FIFO_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(RX_FIFO_DEPTH);

  typedef enum logic {RX_ASM, RX_DRAIN} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  // ---------------------------------------------------------------------------
  // RX assembly
  // ---------------------------------------------------------------------------
  rx_state_e              rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] asm_q, asm_d;
  logic [INSTR_WIDTH-1:0] push_word;
  logic                   err_d, framing_err_q;
  logic [7:0]             err_count_q;
  logic                   rx_hs, fifo_push, fifo_pop;

  logic [INSTR_WIDTH-1:0] mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]      fifo_count_q, fifo_count_d;

  // The final flit is stalled when the FIFO is full. This decision uses only
  // registered state, so a pop in the same cycle does not free the slot early.
  assign rx_flit_ready_o = !((rx_state_q == RX_ASM) && (cnt_q == CNT_LAST) &&
                             (fifo_count_q == FIFO_FULL));
  assign rx_hs = rx_flit_valid_i && rx_flit_ready_o;

  // The completed word is the assembled lower flits plus the incoming last flit.
  always_comb begin
    push_word = asm_q;
    push_word[CNT_LAST*FLIT_WIDTH +: FLIT_WIDTH] = rx_flit_i;
  end

  // RX next state: store flits, push complete packets, flag framing errors.
  always_comb begin
    // NOTE: every signal gets a default first; otherwise unassigned paths infer latches.
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    fifo_push  = 1'b0;
    err_d      = 1'b0;
    if (rx_hs) begin
      case (rx_state_q)
        RX_ASM: begin
          if (cnt_q != CNT_LAST) begin
            if (rx_flit_last_i) begin
              cnt_d = '0;
              err_d = 1'b1;
            end else begin
              asm_d[cnt_q*FLIT_WIDTH +: FLIT_WIDTH] = rx_flit_i;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
            if (rx_flit_last_i) begin
              fifo_push = 1'b1;
            end else begin
              err_d      = 1'b1;
              rx_state_d = RX_DRAIN;
            end
          end
        end
        RX_DRAIN: begin
          if (rx_flit_last_i) begin
            cnt_d      = '0;
            rx_state_d = RX_ASM;
          end
        end
        default: rx_state_d = RX_ASM;
      endcase
    end
  end

  // RX state, assembly buffer and error reporting registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      rx_state_q    <= RX_ASM;
      cnt_q         <= '0;
      asm_q         <= '0;
      framing_err_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      cnt_q         <= cnt_d;
      asm_q         <= asm_d;
      framing_err_q <= err_d;
      if (err_d && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign framing_err_o = framing_err_q;
  assign err_count_o   = err_count_q;

  // ---------------------------------------------------------------------------
  // Instruction FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  assign instr_valid_o   = (fifo_count_q != '0);
  assign fifo_pop        = instr_valid_o && instr_ready_i;
  assign instr_o         = instr_valid_o ? mem[rd_ptr_q] : '0;
  assign rx_fifo_count_o = fifo_count_q;

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    fifo_count_d = fifo_count_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // FIFO storage write.
  // NOTE: storage is not reset; the count gates instr_o, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  // FIFO pointers and occupancy; the pointers wrap explicitly so any depth works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      if (fifo_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [RESP_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  assign resp_ready_o    = (tx_state_q == TX_IDLE);
  assign tx_flit_valid_o = (tx_state_q == TX_SEND);
  assign tx_flit_o       = tx_flit_valid_o ? shift_q[FLIT_WIDTH-1:0] : '0;
  assign tx_flit_last_o  = tx_flit_valid_o && (idx_q == IDX_LAST);

  // TX next state: capture a response, then shift out one flit per handshake.
  always_comb begin
    tx_state_d = tx_state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (resp_valid_i) begin
          shift_d    = resp_i;
          idx_d      = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_flit_ready_i) begin
          shift_d = shift_q >> FLIT_WIDTH;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: tb/tb_chiplet_link_if.sv
// Directed testbench for chiplet_link_if with the default parameters.
// Inputs change 1 ns after the rising edge; outputs are checked at that point too.
module tb_chiplet_link_if;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_flit_valid_i;
  logic [31:0]  rx_flit_i;
  logic         rx_flit_last_i;
  logic         rx_flit_ready_o;
  logic         instr_valid_o;
  logic [127:0] instr_o;
  logic         instr_ready_i;
  logic         resp_valid_i;
  logic [63:0]  resp_i;
  logic         resp_ready_o;
  logic         tx_flit_valid_o;
  logic [31:0]  tx_flit_o;
  logic         tx_flit_last_o;
  logic         tx_flit_ready_i;
  logic         framing_err_o;
  logic [7:0]   err_count_o;
  logic [2:0]   rx_fifo_count_o;

  int n_asserts = 0;
  int n_fail    = 0;

  chiplet_link_if #(
    .FLIT_WIDTH(32), .INSTR_WIDTH(128), .RESP_WIDTH(64), .RX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_flit_valid_i(rx_flit_valid_i), .rx_flit_i(rx_flit_i),
    .rx_flit_last_i(rx_flit_last_i), .rx_flit_ready_o(rx_flit_ready_o),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_ready_i(instr_ready_i),
    .resp_valid_i(resp_valid_i), .resp_i(resp_i), .resp_ready_o(resp_ready_o),
    .tx_flit_valid_o(tx_flit_valid_o), .tx_flit_o(tx_flit_o),
    .tx_flit_last_o(tx_flit_last_o), .tx_flit_ready_i(tx_flit_ready_i),
    .framing_err_o(framing_err_o), .err_count_o(err_count_o),
    .rx_fifo_count_o(rx_fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one flit and hold it until accepted (bounded wait).
  task automatic send_flit(input logic [31:0] d, input logic l);
    int waited = 0;
    rx_flit_valid_i = 1'b1;
    rx_flit_i       = d;
    rx_flit_last_i  = l;
    while (!rx_flit_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    if (!rx_flit_ready_o) check("rx_ready_timeout", rx_flit_ready_o, 128'd1);
    else tick();
    rx_flit_valid_i = 1'b0;
    rx_flit_last_i  = 1'b0;
  endtask

  // Packet p, flit k carries {p, k} in 16-bit halves.
  function automatic logic [31:0] flit(input int p, input int k);
    return {p[15:0], k[15:0]};
  endfunction

  function automatic logic [127:0] word(input int p);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = flit(p, k);
    return w;
  endfunction

  task automatic send_packet(input int p);
    for (int k = 0; k < 4; k++) send_flit(flit(p, k), k == 3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},   rx_flit_ready_o, 128'd1);
    check({tag, "_resp_ready"}, resp_ready_o,    128'd1);
    check({tag, "_ivalid"},     instr_valid_o,   128'd0);
    check({tag, "_instr"},      instr_o,         128'd0);
    check({tag, "_tvalid"},     tx_flit_valid_o, 128'd0);
    check({tag, "_tflit"},      tx_flit_o,       128'd0);
    check({tag, "_tlast"},      tx_flit_last_o,  128'd0);
    check({tag, "_ferr"},       framing_err_o,   128'd0);
    check({tag, "_errcnt"},     err_count_o,     128'd0);
    check({tag, "_fcount"},     rx_fifo_count_o, 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_flit_valid_i = 1'b0; rx_flit_i = '0; rx_flit_last_i = 1'b0;
    instr_ready_i = 1'b0; resp_valid_i = 1'b0; resp_i = '0; tx_flit_ready_i = 1'b0;
    #12;
    check_reset_values("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 1. Single packet
    send_flit(32'h11111111, 1'b0);
    send_flit(32'h22222222, 1'b0);
    send_flit(32'h33333333, 1'b0);
    send_flit(32'h44444444, 1'b1);
    check("t1_valid", instr_valid_o, 128'd1);
    check("t1_word",  instr_o, 128'h44444444_33333333_22222222_11111111);
    check("t1_count", rx_fifo_count_o, 128'd1);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("t1_popped", rx_fifo_count_o, 128'd0);

    // 2. FIFO full and backpressure
    for (int p = 1; p <= 4; p++) send_packet(p);
    check("t2_full_count", rx_fifo_count_o, 128'd4);
    check("t2_ready_cnt0", rx_flit_ready_o, 128'd1);
    for (int k = 0; k < 3; k++) send_flit(flit(5, k), 1'b0);
    rx_flit_valid_i = 1'b1; rx_flit_i = flit(5, 3); rx_flit_last_i = 1'b1;
    check("t2_stall", rx_flit_ready_o, 128'd0);
    tick();
    check("t2_stall_hold", rx_flit_ready_o, 128'd0);
    check("t2_count_hold", rx_fifo_count_o, 128'd4);
    check("t2_head1", instr_o, word(1));
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("t2_after_pop", rx_fifo_count_o, 128'd3);
    check("t2_ready_back", rx_flit_ready_o, 128'd1);
    tick();
    rx_flit_valid_i = 1'b0; rx_flit_last_i = 1'b0;
    check("t2_pkt5_in", rx_fifo_count_o, 128'd4);
    for (int p = 2; p <= 5; p++) begin
      check($sformatf("t2_head%0d", p), instr_o, word(p));
      instr_ready_i = 1'b1;
      tick();
      instr_ready_i = 1'b0;
    end
    check("t2_empty", instr_valid_o, 128'd0);

    // 3. Early last
    send_flit(32'hAAAA0000, 1'b0);
    send_flit(32'hAAAA0001, 1'b1);
    check("t3_pulse", framing_err_o, 128'd1);
    check("t3_errcnt", err_count_o, 128'd1);
    check("t3_count", rx_fifo_count_o, 128'd0);
    tick();
    check("t3_pulse_end", framing_err_o, 128'd0);
    send_packet(6);
    check("t3_good", instr_o, word(6));
    check("t3_good_cnt", rx_fifo_count_o, 128'd1);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;

    // 4. Missing last
    for (int k = 0; k < 4; k++) send_flit(32'hBBBB0000 + k, 1'b0);
    check("t4_pulse", framing_err_o, 128'd1);
    check("t4_errcnt", err_count_o, 128'd2);
    send_flit(32'hBBBB0004, 1'b0);
    check("t4_no_pulse_a", framing_err_o, 128'd0);
    send_flit(32'hBBBB0005, 1'b1);
    check("t4_no_pulse_b", framing_err_o, 128'd0);
    check("t4_errcnt_hold", err_count_o, 128'd2);
    check("t4_dropped", rx_fifo_count_o, 128'd0);
    send_packet(7);
    check("t4_good", instr_o, word(7));
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;

    // 5. Response serialization
    resp_i = 64'hDEADBEEF_CAFEF00D;
    resp_valid_i = 1'b1;
    check("t5_resp_ready0", resp_ready_o, 128'd1);
    tick();
    resp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t5_valid_c%0d", c), tx_flit_valid_o, 128'd1);
      check($sformatf("t5_flit0_c%0d", c), tx_flit_o, 128'hCAFEF00D);
      check($sformatf("t5_last0_c%0d", c), tx_flit_last_o, 128'd0);
      check($sformatf("t5_rready_c%0d", c), resp_ready_o, 128'd0);
      if (c < 2) tick();
    end
    tx_flit_ready_i = 1'b1;
    tick();
    check("t5_flit1", tx_flit_o, 128'hDEADBEEF);
    check("t5_last1", tx_flit_last_o, 128'd1);
    check("t5_rready_mid", resp_ready_o, 128'd0);
    tick();
    tx_flit_ready_i = 1'b0;
    check("t5_done_valid", tx_flit_valid_o, 128'd0);
    check("t5_rready_back", resp_ready_o, 128'd1);

    // Error counter saturation: lone last flits are early-last errors.
    for (int i = 0; i < 260; i++) send_flit(32'h0, 1'b1);
    check("sat_errcnt", err_count_o, 128'd255);

    // 6. Reset mid-packet, with a queued word and a stalled response
    send_packet(8);
    resp_i = 64'h01234567_89ABCDEF;
    resp_valid_i = 1'b1;
    tick();
    resp_valid_i = 1'b0;
    check("t6_tx_busy", tx_flit_valid_o, 128'd1);
    send_flit(32'hCCCC0000, 1'b0);
    send_flit(32'hCCCC0001, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_values("t6_rst");
    rst_n = 1'b1;
    tx_flit_ready_i = 1'b1;
    tick();
    tick();
    check("t6_no_tx", tx_flit_valid_o, 128'd0);
    tx_flit_ready_i = 1'b0;
    send_flit(32'h55555555, 1'b0);
    send_flit(32'h66666666, 1'b0);
    send_flit(32'h77777777, 1'b0);
    send_flit(32'h88888888, 1'b1);
    check("t6_word", instr_o, 128'h88888888_77777777_66666666_55555555);
    check("t6_count", rx_fifo_count_o, 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
